// File: rtl/seq_alu_param.sv
// Multi-cycle WIDTH-bit ALU: add/sub in one cycle, radix-2 Booth multiply, restoring divide.
// Optional macro SEQ_ALU_ABORT_EN adds an abort input that cancels an operation in flight.
module seq_alu_param #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
`ifdef SEQ_ALU_ABORT_EN
    input  logic               abort,
`endif
    input  logic [1:0]         op_code,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   operand_A,
    input  logic [WIDTH-1:0]   operand_B,
    output logic [2*WIDTH-1:0] alu_result,
    output logic [3:0]         flags,
    output logic               busy,
    output logic               alu_done
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        ADDSUB,
        MUL_ITER,
        DIV_ITER,
        DIV_FIX,
        DONE
    } state_t;

    state_t state, next_state;
    logic [CNT_W-1:0] cnt;

    logic               accept;
    logic               abort_hit;
    logic               sub_q;
    logic               smode_q;
    logic               dz_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;

    logic signed [WIDTH+1:0] m_ext;
    logic signed [WIDTH+1:0] acc;
    logic signed [WIDTH+1:0] acc_sum;
    logic signed [WIDTH+1:0] acc_sh;
    logic [WIDTH-1:0]        mq;
    logic [WIDTH-1:0]        mq_sh;
    logic                    q_m1;
    logic [WIDTH-1:0]        prod_hi;

    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   dvsr;
    logic               neg_q;
    logic               neg_r;
    logic [WIDTH:0]     div_shift;
    logic               div_fits;
    logic [WIDTH-1:0]   rem_next;

    logic [WIDTH-1:0]   b_eff;
    logic [WIDTH:0]     addsub_sum;

    logic               res_we;
    logic [2*WIDTH-1:0] res_next;
    logic               ovf_next;
    logic               carry_next;
    logic               dbz_next;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    assign accept   = start && (state == IDLE || state == DONE);
    assign busy     = (state == ADDSUB) || (state == MUL_ITER) || (state == DIV_ITER) || (state == DIV_FIX);
    assign alu_done = (state == DONE);

`ifdef SEQ_ALU_ABORT_EN
    assign abort_hit = abort && busy;
`else
    assign abort_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            if (accept)
                cnt <= '0;
            else if (state == MUL_ITER || state == DIV_ITER)
                cnt <= cnt + CNT_W'(1);
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: begin
                next_state = IDLE;
                if (start) begin
                    case (op_code)
                        2'b10:   next_state = MUL_ITER;
                        // A zero divisor skips the iterations entirely.
                        2'b11:   next_state = (operand_B == '0) ? DIV_FIX : DIV_ITER;
                        default: next_state = ADDSUB;
                    endcase
                end
            end
            ADDSUB:   next_state = DONE;
            MUL_ITER: if (cnt == CNT_LAST) next_state = DONE;
            DIV_ITER: if (cnt == CNT_LAST) next_state = DIV_FIX;
            DIV_FIX:  next_state = DONE;
            default:  next_state = IDLE;
        endcase
        if (abort_hit)
            next_state = IDLE;
    end

    // Booth step on {acc, mq, q_m1}; unsigned multipliers get +M<<WIDTH for their top bit.
    always_comb begin
        acc_sum = acc;
        case ({mq[0], q_m1})
            2'b01:   acc_sum = acc + m_ext;
            2'b10:   acc_sum = acc - m_ext;
            default: acc_sum = acc;
        endcase
    end

    assign acc_sh  = acc_sum >>> 1;
    assign mq_sh   = {acc_sum[0], mq[WIDTH-1:1]};
    assign prod_hi = acc_sh[WIDTH-1:0] + ((!smode_q && b_q[WIDTH-1]) ? m_ext[WIDTH-1:0] : '0);

    assign div_shift = {rem, quo[WIDTH-1]};
    assign div_fits  = div_shift >= {1'b0, dvsr};
    assign rem_next  = div_fits ? (div_shift[WIDTH-1:0] - dvsr) : div_shift[WIDTH-1:0];

    assign b_eff      = sub_q ? ~b_q : b_q;
    assign addsub_sum = {1'b0, a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_q};

    // Operand latch and iteration datapath
    always_ff @(posedge clk) begin
        if (accept) begin
            sub_q   <= op_code[0];
            smode_q <= signed_mode;
            a_q     <= operand_A;
            b_q     <= operand_B;
            dz_q    <= (op_code == 2'b11) && (operand_B == '0);
        end
        if (state == MUL_ITER) begin
            if (cnt == '0) begin
                m_ext <= {{2{smode_q & a_q[WIDTH-1]}}, a_q};
                acc   <= '0;
                mq    <= b_q;
                q_m1  <= 1'b0;
            end else begin
                acc  <= acc_sh;
                mq   <= mq_sh;
                q_m1 <= mq[0];
            end
        end
        if (state == DIV_ITER) begin
            if (cnt == '0) begin
                quo   <= magnitude(a_q, smode_q);
                dvsr  <= magnitude(b_q, smode_q);
                rem   <= '0;
                neg_q <= smode_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                neg_r <= smode_q && a_q[WIDTH-1];
            end else begin
                rem <= rem_next;
                quo <= {quo[WIDTH-2:0], div_fits};
            end
        end
    end

    // Result and flag selection
    always_comb begin
        res_we     = 1'b0;
        res_next   = '0;
        ovf_next   = 1'b0;
        carry_next = 1'b0;
        dbz_next   = 1'b0;
        case (state)
            ADDSUB: begin
                res_we     = 1'b1;
                res_next   = {{WIDTH{1'b0}}, addsub_sum[WIDTH-1:0]};
                carry_next = addsub_sum[WIDTH];
                ovf_next   = smode_q && (a_q[WIDTH-1] == b_eff[WIDTH-1])
                             && (addsub_sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            MUL_ITER: begin
                if (cnt == CNT_LAST) begin
                    res_we   = 1'b1;
                    res_next = {prod_hi, mq_sh};
                end
            end
            DIV_FIX: begin
                res_we = 1'b1;
                if (dz_q) begin
                    res_next = {a_q, {WIDTH{1'b1}}};
                    dbz_next = 1'b1;
                end else begin
                    res_next = {apply_sign(rem, neg_r), apply_sign(quo, neg_q)};
                    ovf_next = smode_q && (a_q == MIN_VAL) && (&b_q);
                end
            end
            default: res_we = 1'b0;
        endcase
        if (abort_hit)
            res_we = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            alu_result <= '0;
            flags      <= '0;
        end else if (res_we) begin
            alu_result <= res_next;
            flags      <= {dbz_next, ovf_next, carry_next, (res_next == '0)};
        end
    end

endmodule

// File: tb/tb_seq_alu_param.sv
// Scoreboard bench for seq_alu_param (WIDTH=8): expected result, flags and latency are queued
// at issue and compared when alu_done pulses.
module tb_seq_alu_param;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [1:0]     op_code;
    logic           signed_mode;
    logic [W-1:0]   operand_A;
    logic [W-1:0]   operand_B;
    logic [2*W-1:0] alu_result;
    logic [3:0]     flags;
    logic           busy;
    logic           alu_done;
`ifdef SEQ_ALU_ABORT_EN
    logic           abort;
`endif

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int busy_cnt     = 0;

    typedef struct {
        string          tag;
        logic [2*W-1:0] res;
        logic [3:0]     fl;
        int             lat;
        int             acc_cyc;
    } exp_t;

    exp_t sb_q[$];

    seq_alu_param #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
`ifdef SEQ_ALU_ABORT_EN
        .abort       (abort),
`endif
        .op_code     (op_code),
        .signed_mode (signed_mode),
        .operand_A   (operand_A),
        .operand_B   (operand_B),
        .alu_result  (alu_result),
        .flags       (flags),
        .busy        (busy),
        .alu_done    (alu_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference arithmetic on plain integers.
    function automatic void model(input logic [1:0] op, input logic sm,
                                  input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [2*W-1:0] res, output logic [3:0] fl,
                                  output int lat);
        longint va, vb, ua, ub, r, q, rm, lim, smax, smin;
        logic ov, cy, dz;
        ov = 1'b0; cy = 1'b0; dz = 1'b0;
        ua   = longint'(a);
        ub   = longint'(b);
        va   = sm ? longint'($signed(a)) : ua;
        vb   = sm ? longint'($signed(b)) : ub;
        lim  = longint'(1) << W;
        smax = (longint'(1) << (W - 1)) - 1;
        smin = -(longint'(1) << (W - 1));
        res  = '0;
        lat  = 1;
        case (op)
            2'd0: begin
                r   = va + vb;
                cy  = (ua + ub) >= lim;
                ov  = sm && (r > smax || r < smin);
                res = {{W{1'b0}}, r[W-1:0]};
            end
            2'd1: begin
                r   = va - vb;
                cy  = ua >= ub;
                ov  = sm && (r > smax || r < smin);
                res = {{W{1'b0}}, r[W-1:0]};
            end
            2'd2: begin
                r   = va * vb;
                res = r[2*W-1:0];
                lat = W + 1;
            end
            default: begin
                if (b == '0) begin
                    res = {a, {W{1'b1}}};
                    dz  = 1'b1;
                end else begin
                    q   = va / vb;
                    rm  = va % vb;
                    res = {rm[W-1:0], q[W-1:0]};
                    ov  = sm && (q > smax);
                    lat = W + 2;
                end
            end
        endcase
        fl = {dz, ov, cy, (res == '0)};
    endfunction

    // Called on a falling edge; the next rising edge accepts the request.
    task automatic issue(input string tag, input logic [1:0] op, input logic sm,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W-1:0] eres, input logic [3:0] efl,
                         input int elat, input bit push);
        exp_t e;
        op_code     = op;
        signed_mode = sm;
        operand_A   = a;
        operand_B   = b;
        start       = 1'b1;
        if (push) begin
            e.tag     = tag;
            e.res     = eres;
            e.fl      = efl;
            e.lat     = elat;
            e.acc_cyc = cyc + 1;
            sb_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while ((sb_q.size() != 0 || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            chk("timeout", 64'(sb_q.size()), 64'd0);
            sb_q.delete();
        end
    endtask

    task automatic run_model(input string tag, input logic [1:0] op, input logic sm,
                             input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] r;
        logic [3:0]     f;
        int             l;
        model(op, sm, a, b, r, f, l);
        issue(tag, op, sm, a, b, r, f, l, 1'b1);
        wait_done(40);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (busy) begin
                busy_cnt++;
            end else if (alu_done) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk({e.tag, "_res"}, 64'(alu_result), 64'(e.res));
                    chk({e.tag, "_flags"}, 64'(flags), 64'(e.fl));
                    chk({e.tag, "_latency"}, 64'(cyc - e.acc_cyc), 64'(e.lat));
                    chk({e.tag, "_busy_cycles"}, 64'(busy_cnt), 64'(e.lat));
                end
                busy_cnt = 0;
            end else begin
                busy_cnt = 0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got %0d cycles expected fewer", cyc);
        $fatal(1);
    end

    initial begin : stimulus
        reset       = 1'b1;
        start       = 1'b0;
        op_code     = 2'b00;
        signed_mode = 1'b0;
        operand_A   = '0;
        operand_B   = '0;
`ifdef SEQ_ALU_ABORT_EN
        abort       = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(alu_done), 64'd0);
        chk("rst_result", 64'(alu_result), 64'd0);
        chk("rst_flags", 64'(flags), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        issue("add_u_200_100", 2'd0, 1'b0, 8'd200, 8'd100, 16'h002C, 4'b0010, 1, 1'b1);
        wait_done(40);
        issue("sub_s_100_m100", 2'd1, 1'b1, 8'h64, 8'h9C, 16'h00C8, 4'b0100, 1, 1'b1);
        wait_done(40);
        issue("sub_u_5_9", 2'd1, 1'b0, 8'd5, 8'd9, 16'h00FC, 4'b0000, 1, 1'b1);
        wait_done(40);
        issue("mul_s_m7_6", 2'd2, 1'b1, 8'hF9, 8'h06, 16'hFFD6, 4'b0000, 9, 1'b1);
        wait_done(40);
        issue("mul_u_255_255", 2'd2, 1'b0, 8'hFF, 8'hFF, 16'hFE01, 4'b0000, 9, 1'b1);
        wait_done(40);
        issue("mul_s_0_m128", 2'd2, 1'b1, 8'h00, 8'h80, 16'h0000, 4'b0001, 9, 1'b1);
        wait_done(40);
        issue("div_u_200_13", 2'd3, 1'b0, 8'd200, 8'd13, 16'h050F, 4'b0000, 10, 1'b1);
        wait_done(40);
        issue("div_s_m7_2", 2'd3, 1'b1, 8'hF9, 8'h02, 16'hFFFD, 4'b0000, 10, 1'b1);
        wait_done(40);
        issue("div_s_min_m1", 2'd3, 1'b1, 8'h80, 8'hFF, 16'h0080, 4'b0100, 10, 1'b1);
        wait_done(40);

        // Divide by zero followed by a start accepted in the DONE cycle.
        issue("div_77_0", 2'd3, 1'b0, 8'd77, 8'd0, 16'h4DFF, 4'b1000, 1, 1'b1);
        @(negedge clk);
        chk("b2b_in_done", 64'(alu_done), 64'd1);
        issue("b2b_add_1_1", 2'd0, 1'b0, 8'd1, 8'd1, 16'h0002, 4'b0000, 1, 1'b1);
        wait_done(40);

        // A start while busy must not disturb the multiply.
        issue("mul_ignore_start", 2'd2, 1'b1, 8'hF9, 8'h06, 16'hFFD6, 4'b0000, 9, 1'b1);
        repeat (3) @(negedge clk);
        op_code   = 2'd0;
        operand_A = 8'd3;
        operand_B = 8'd3;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(40);

        // Reset in the middle of a divide.
        issue("div_reset", 2'd3, 1'b0, 8'd200, 8'd13, 16'h0000, 4'b0000, 0, 1'b0);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(alu_done), 64'd0);
        chk("midrst_result", 64'(alu_result), 64'd0);
        chk("midrst_flags", 64'(flags), 64'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("postrst_busy", 64'(busy), 64'd0);

        for (int i = 0; i < 32; i++) begin
            logic [1:0]   rop;
            logic         rsm;
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            rop = 2'($urandom_range(0, 3));
            rsm = 1'($urandom_range(0, 1));
            ra  = W'($urandom);
            rb  = (i % 8 == 7) ? '0 : W'($urandom);
            run_model("rand", rop, rsm, ra, rb);
        end

`ifdef SEQ_ALU_ABORT_EN
        issue("abort_setup", 2'd0, 1'b0, 8'h12, 8'h34, 16'h0046, 4'b0000, 1, 1'b1);
        wait_done(40);
        issue("mul_abort", 2'd2, 1'b0, 8'd5, 8'd5, 16'h0000, 4'b0000, 0, 1'b0);
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        repeat (W + 4) @(negedge clk);
        chk("abort_result", 64'(alu_result), 64'h0046);
        chk("abort_flags", 64'(flags), 64'd0);
`endif

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
